sar_logic: RTL and testbench
============================

// Module: sar_logic
// PURPOSE
//  Successive-approximation controller for the 8-bit SAR ADC. Drives the track/hold switch and the
//  capacitive-DAC code, reads the comparator, and produces the binary conversion result.
//  The result bus feeds the SPI slave's parallel din, so the master shifts out the latest conversion.
//  It sits between the analog core (comparator, DAC, T/H) and the SPI readout stage.
// PARAMETERS
//  N_BITS         8  resolution; legal range 2..16
//  SAMPLE_CYCLES  2  clk cycles the T/H stays in track (sample=1); must be >=1
//  SETTLE_CYCLES  1  clk cycles allowed for DAC/comparator settling per bit; must be >=1
// PORTS
//  clk       in   1       system clock, rising-edge
//  rst       in   1       synchronous reset, active-high
//  start     in   1       conversion request; sampled only in IDLE
//  cmp       in   1       comparator: 1 = Vin >= Vdac (keep trial bit), 0 = clear trial bit
//  sample    out  1       T/H control: 1 = track, 0 = hold
//  dac_code  out  N_BITS  trial code to capacitive DAC
//  busy      out  1       1 whenever state != IDLE
//  done      out  1       single-cycle pulse; result is valid from the same cycle
//  result    out  N_BITS  last completed conversion; stable until the next done
// BEHAVIOUR
//  - Single clock domain; all outputs are registered.
//  - Reset (rst=1 at an edge): state=IDLE. sample=0, dac_code=0, busy=0, done=0, result=0.
//    Reset overrides any state, including a conversion in progress; the partial code is discarded.
//  - FSM states: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
//    IDLE:   start=1 -> SAMPLE with sample=1; load the sample counter. dac_code holds its last value.
//    SAMPLE: stay SAMPLE_CYCLES cycles. On leaving:
//            sample=0, bit idx=N_BITS-1, dac_code=1<<(N_BITS-1) (midscale), -> SETTLE.
//    SETTLE: stay SETTLE_CYCLES cycles; then -> DECIDE. cmp is ignored here.
//    DECIDE: if cmp=0, clear dac_code[idx].
//            If idx>0: set dac_code[idx-1], idx--, -> SETTLE.
//            If idx=0: result<=final code, -> DONE.
//    DONE:   done=1 for this one cycle; busy still 1; -> IDLE. dac_code keeps the final code.
//  - start is ignored in every state except IDLE; no queueing, no error flag.
//    A start held high gives back-to-back conversions.
//  - Timing, with E0 = the edge that accepts start:
//    result is updated and done rises at edge E0+SAMPLE_CYCLES+N_BITS*(SETTLE_CYCLES+1).
//    With the defaults this is E18. done falls at E19, and the next accepted start is E20.
//    Conversion period is therefore SAMPLE_CYCLES+N_BITS*(SETTLE_CYCLES+1)+2 = 20 cycles.
//  - cmp is sampled only on the DECIDE edge; it is treated as synchronous and stable by then.
//  - Code arithmetic is bitwise only (set/clear); no overflow is possible.
//    Full-scale input gives all ones; zero input gives all zeros.
// TESTING
//  1. rst=1 for 2 cycles with start=1 -> all outputs 0; no SAMPLE entry while rst=1.
//  2. Behavioural cmp = (0xA5 >= dac_code), single start pulse ->
//     trial sequence 80,C0,A0,B0,A8,A4,A6,A5; result=0xA5.
//     done is high exactly one cycle, at E18.
//  3. Vin=0x00 (cmp always 0) -> result=0x00. Vin=0xFF (cmp always 1) -> result=0xFF.
//     Both complete at E18.
//  4. start held high for 3 conversions with Vin=0x3C -> done pulses at E18, E38 and E58.
//     result=0x3C each time. sample=1 during cycles E0..E1, E20..E21 and E40..E41.
//  5. Extra start pulses at E5 and E17 -> ignored: busy stays 1 and done occurs only at E18.
//  6. rst asserted at the bit-4 DECIDE edge -> next cycle all outputs 0.
//     A following start with Vin=0x81 -> result=0x81.

Source files
------------

// File: rtl/sar_logic.sv
// rtl/sar_logic.sv - successive-approximation controller for the SAR ADC
//
// Sequences the track/hold switch and capacitive-DAC trial code, reads the
// comparator once per bit, and publishes the binary conversion result.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active high
//   start     in   1       conversion request, honoured only when idle
//   cmp       in   1       comparator: 1 = Vin >= Vdac (keep trial bit)
//   sample    out  1       T/H control: 1 = track, 0 = hold
//   dac_code  out  N_BITS  trial code driven to the capacitive DAC
//   busy      out  1       high whenever a conversion is in flight
//   done      out  1       one-cycle pulse, result valid from the same cycle
//   result    out  N_BITS  last completed conversion

module sar_logic #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);

    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(N_BITS);

    localparam logic [N_BITS-1:0] ONE      = N_BITS'(1);
    localparam logic [N_BITS-1:0] MIDSCALE = ONE << (N_BITS - 1);
    localparam logic [CW-1:0]     SAMP_LD  = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]     SETL_LD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_TOP  = IW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [N_BITS-1:0] code_kept;

    // Trial code after the comparator verdict on the bit under test.
    always_comb begin
        code_kept = dac_code;
        if (!cmp) begin
            code_kept[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SAMPLE;
                        cnt    <= SAMP_LD;
                        sample <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        state    <= SETTLE;
                        cnt      <= SETL_LD;
                        sample   <= 1'b0;
                        idx      <= IDX_TOP;
                        dac_code <= MIDSCALE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= DECIDE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DECIDE: begin
                    if (idx != '0) begin
                        // Resolve this bit and raise the next lower trial bit.
                        dac_code <= code_kept | (ONE << (idx - IW'(1)));
                        idx      <= idx - IW'(1);
                        cnt      <= SETL_LD;
                        state    <= SETTLE;
                    end else begin
                        dac_code <= code_kept;
                        result   <= code_kept;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    sample <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// tb/tb_sar_logic.sv - scoreboard testbench for sar_logic

module tb_sar_logic;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cmp;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] vin;
    int         cyc;
    int         e0;
    int         checks;
    int         errors;

    typedef struct {
        logic [7:0] res;
        int         edge_no;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] trace[$];

    sar_logic #(
        .N_BITS        (8),
        .SAMPLE_CYCLES (2),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp      (cmp),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Behavioural comparator modelling the analog input level.
    assign cmp = (vin >= dac_code);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("done_edge", cyc, e.edge_no);
            end
        end
        if (busy === 1'b1 && sample === 1'b0 &&
            (trace.size() == 0 || trace[$] !== dac_code)) begin
            trace.push_back(dac_code);
        end
    end

    // Advance to the falling edge following edge E0+k.
    task automatic go_to(input int k);
        while (cyc < e0 + k) @(negedge clk);
    endtask

    // Drive start for one cycle; E0 is the very next rising edge.
    task automatic start_conv(input logic [7:0] v, input bit expect_done);
        exp_t e;
        vin   = v;
        start = 1'b1;
        e0    = cyc + 1;
        if (expect_done) begin
            e.res     = v;
            e.edge_no = e0 + 18;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_trace[8];
        exp_t       e;

        exp_trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        checks = 0;
        errors = 0;
        vin    = 8'h00;
        rst    = 1'b1;
        start  = 1'b1;
        e0     = 0;

        // 1: reset held with start asserted.
        repeat (2) begin
            @(negedge clk);
            chk("rst_sample", int'(sample), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_dac", int'(dac_code), 0);
            chk("rst_result", int'(result), 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // 2: Vin = 0xA5, check trial sequence.
        trace.delete();
        start_conv(8'hA5, 1'b1);
        go_to(19);
        chk("trace_len", trace.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < trace.size()) chk("trace_code", int'(trace[i]), int'(exp_trace[i]));
        end
        chk("done_low_e19", int'(done), 0);
        go_to(20);

        // 3: zero and full-scale inputs.
        start_conv(8'h00, 1'b1);
        go_to(20);
        start_conv(8'hFF, 1'b1);
        go_to(20);

        // 4: start held high for three back-to-back conversions.
        vin   = 8'h3C;
        start = 1'b1;
        e0    = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.res     = 8'h3C;
            e.edge_no = e0 + 18 + 20 * k;
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            go_to(20 * k);
            chk("bb_sample_t0", int'(sample), 1);
            go_to(20 * k + 1);
            chk("bb_sample_t1", int'(sample), 1);
            go_to(20 * k + 2);
            chk("bb_sample_hold", int'(sample), 0);
        end
        start = 1'b0;
        go_to(60);
        chk("bb_idle", int'(busy), 0);

        // 5: stray start pulses mid-conversion are ignored.
        start_conv(8'h5A, 1'b1);
        go_to(4);
        start = 1'b1;
        go_to(5);
        start = 1'b0;
        chk("stray_busy_e5", int'(busy), 1);
        go_to(16);
        start = 1'b1;
        go_to(17);
        start = 1'b0;
        chk("stray_busy_e17", int'(busy), 1);
        go_to(20);
        chk("stray_idle_e20", int'(busy), 0);

        // 6: reset at the bit-4 DECIDE edge, then convert 0x81.
        start_conv(8'hA5, 1'b0);
        go_to(9);
        rst = 1'b1;
        go_to(10);
        chk("abort_sample", int'(sample), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);
        start_conv(8'h81, 1'b1);
        go_to(22);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
